// File: rtl/acc_op_scheduler.sv
// Two-requester, round-robin scheduler around one shared WIDTH-bit accumulator ALU with an iterative divider.
// Optional build macro ACC_SAT_EN: ADD/SUB become signed-saturating and rsp_sat reports clamping.
module acc_op_scheduler #(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [7:0]           req_op,
    input  logic [2*WIDTH-1:0]   req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_err,
    output logic                 rsp_sat,
    output logic                 busy
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_MOD  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_ASHL = 4'd11;
    localparam logic [3:0] OP_ASHR = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_acc;
    logic              r_rr_ptr;
    logic              r_rsp_id;
    logic              r_rsp_err;
    logic              r_rsp_sat;

    logic [WIDTH-1:0]  r_div_rem;
    logic [WIDTH-1:0]  r_div_quo;
    logic [WIDTH-1:0]  r_div_dvsr;
    logic              r_div_is_mod;
    logic [SW-1:0]     r_div_cnt;

    logic              w_any;
    logic              w_win;
    logic              w_accept;
    logic [3:0]        w_op;
    logic [WIDTH-1:0]  w_d;
    logic [SW-1:0]     w_sh;
    logic              w_is_div;
    logic [WIDTH-1:0]  w_alu;
    logic              w_alu_err;
    logic              w_alu_sat;

    logic [WIDTH:0]    w_div_shift;
    logic              w_div_ge;
    logic [WIDTH-1:0]  w_div_rem_nxt;
    logic [WIDTH-1:0]  w_div_quo_nxt;
    logic              w_div_last;

`ifdef ACC_SAT_EN
    // Returns {saturated, result} for a signed add (sub=0) or subtract (sub=1).
    function automatic logic [WIDTH:0] sat_addsub(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sub);
        logic signed [WIDTH:0] ea;
        logic signed [WIDTH:0] eb;
        logic signed [WIDTH:0] r;
        ea = {a[WIDTH-1], a};
        eb = {b[WIDTH-1], b};
        r  = sub ? (ea - eb) : (ea + eb);
        if (r[WIDTH] != r[WIDTH-1]) begin
            if (r[WIDTH])
                return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        end
        return {1'b0, r[WIDTH-1:0]};
    endfunction
`endif

    always_comb begin
        w_any = 1'b0;
        w_win = 1'b0;
        case (req_valid)
            2'b01:   begin w_any = 1'b1; w_win = 1'b0;     end
            2'b10:   begin w_any = 1'b1; w_win = 1'b1;     end
            2'b11:   begin w_any = 1'b1; w_win = r_rr_ptr; end
            default: begin w_any = 1'b0; w_win = 1'b0;     end
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && w_any && !rst;
    assign req_ready = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign w_op      = w_win ? req_op[7:4] : req_op[3:0];
    assign w_d       = w_win ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    assign w_sh      = w_d[SW-1:0];
    assign w_is_div  = (w_op == OP_DIV) || (w_op == OP_MOD);

    always_comb begin
        w_alu     = r_acc;
        w_alu_err = 1'b0;
        w_alu_sat = 1'b0;
        case (w_op)
            OP_LOAD: w_alu = w_d;
`ifdef ACC_SAT_EN
            OP_ADD:  {w_alu_sat, w_alu} = sat_addsub(r_acc, w_d, 1'b0);
            OP_SUB:  {w_alu_sat, w_alu} = sat_addsub(r_acc, w_d, 1'b1);
`else
            OP_ADD:  w_alu = r_acc + w_d;
            OP_SUB:  w_alu = r_acc - w_d;
`endif
            OP_MUL:  w_alu = r_acc * w_d;
            OP_DIV,
            OP_MOD:  w_alu = r_acc;
            OP_AND:  w_alu = r_acc & w_d;
            OP_OR:   w_alu = r_acc | w_d;
            OP_XOR:  w_alu = r_acc ^ w_d;
            OP_SHL,
            OP_ASHL: w_alu = r_acc << w_sh;
            OP_SHR:  w_alu = r_acc >> w_sh;
            OP_ASHR: w_alu = $unsigned($signed(r_acc) >>> w_sh);
            default: w_alu_err = 1'b1;
        endcase
    end

    // Restoring divider step: a zero divisor yields an all-ones quotient and the dividend as remainder.
    assign w_div_shift   = {r_div_rem, r_div_quo[WIDTH-1]};
    assign w_div_ge      = w_div_shift >= {1'b0, r_div_dvsr};
    assign w_div_rem_nxt = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_div_dvsr) : w_div_shift[WIDTH-1:0];
    assign w_div_quo_nxt = {r_div_quo[WIDTH-2:0], w_div_ge};
    assign w_div_last    = (r_div_cnt == SW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_is_div ? S_DIV : S_RESP;
            S_DIV:  if (w_div_last) w_state_nxt = S_RESP;
            S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= RST_VAL;
            r_rr_ptr  <= 1'b0;
            r_rsp_id  <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rsp_sat <= 1'b0;
        end else if (w_accept) begin
            r_rsp_id  <= w_win;
            r_rsp_err <= w_is_div ? 1'b0 : w_alu_err;
            r_rsp_sat <= w_is_div ? 1'b0 : w_alu_sat;
            if (!w_is_div)
                r_acc <= w_alu;
            if (req_valid == 2'b11)
                r_rr_ptr <= ~w_win;
        end else if (r_state == S_DIV && w_div_last) begin
            r_acc <= r_div_is_mod ? w_div_rem_nxt : w_div_quo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_div_rem    <= '0;
            r_div_quo    <= r_acc;
            r_div_dvsr   <= w_d;
            r_div_is_mod <= (w_op == OP_MOD);
            r_div_cnt    <= '0;
        end else if (r_state == S_DIV) begin
            r_div_rem <= w_div_rem_nxt;
            r_div_quo <= w_div_quo_nxt;
            r_div_cnt <= r_div_cnt + SW'(1);
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = rsp_valid ? r_acc : '0;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;
    assign rsp_sat   = r_rsp_sat;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_acc_op_scheduler.sv
// Randomized and directed bench for acc_op_scheduler against a plain-arithmetic accumulator model.
module tb_acc_op_scheduler;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [7:0]    req_op;
    logic [63:0]   req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          rsp_sat;
    logic          busy;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   m_acc;
    int            m_rr;
    logic [31:0]   last_data;

    always #5 clk = ~clk;

    acc_op_scheduler #(.WIDTH(W), .RST_VAL(32'h0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_sat(rsp_sat), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one command on the accumulator.
    function automatic void model(input logic [31:0] a, input logic [3:0] op, input logic [31:0] d,
                                  output logic [31:0] r, output logic e, output logic s);
        int     sh;
        longint sum;
        sh  = int'(d[4:0]);
        r   = a;
        e   = 1'b0;
        s   = 1'b0;
        sum = 0;
        case (op)
            4'd0: r = d;
            4'd1, 4'd2: begin
`ifdef ACC_SAT_EN
                if (op == 4'd1) sum = longint'($signed(a)) + longint'($signed(d));
                else            sum = longint'($signed(a)) - longint'($signed(d));
                if (sum > 64'sd2147483647)       begin r = 32'h7FFF_FFFF; s = 1'b1; end
                else if (sum < -64'sd2147483648) begin r = 32'h8000_0000; s = 1'b1; end
                else r = sum[31:0];
`else
                r = (op == 4'd1) ? a + d : a - d;
`endif
            end
            4'd3: r = a * d;
            4'd4: r = (d == 0) ? 32'hFFFF_FFFF : a / d;
            4'd5: r = (d == 0) ? a : a % d;
            4'd6: r = a & d;
            4'd7: r = a | d;
            4'd8: r = a ^ d;
            4'd9, 4'd11: r = a << sh;
            4'd10: r = a >> sh;
            4'd12: r = $signed(a) >>> sh;
            default: e = 1'b1;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        m_acc = 32'h0;
        m_rr = 0;
    endtask

    task automatic issue(input int id, input logic [3:0] op, input logic [31:0] d, input int hold);
        logic [31:0] er;
        logic        ee;
        logic        es;
        int          t;
        int          lat;
        model(m_acc, op, d, er, ee, es);
        req_op[id*4 +: 4]    = op;
        req_data[id*32 +: 32] = d;
        req_valid[id]        = 1'b1;
        #1;
        t = 0;
        while (req_ready[id] !== 1'b1 && t < 50) begin step(); t++; end
        chk("grant", {62'd0, req_ready}, (id == 1) ? 64'd2 : 64'd1);
        step();
        req_valid[id] = 1'b0;
        m_acc = er;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            if (lat == 10) chk("div_busy", {61'd0, busy, req_ready}, 64'h4);
            step();
            lat++;
        end
        chk("latency", lat, (op == 4'd4 || op == 4'd5) ? W + 1 : 1);
        chk("rsp_data", rsp_data, er);
        chk("rsp_id", rsp_id, id);
        chk("rsp_err", rsp_err, ee);
        chk("rsp_sat", rsp_sat, es);
        last_data = rsp_data;
        for (int k = 0; k < hold; k++) begin
            step();
            chk("hold", {rsp_valid, rsp_id, req_ready, rsp_err, rsp_sat, rsp_data},
                {1'b1, id[0], 2'b00, ee, es, er});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_done", {rsp_valid, busy}, 2'b00);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_op = '0;
        req_data = '0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        rst = 1'b1;
        last_data = '0;
        step();
        req_valid = 2'b11;
        #1;
        chk("reset_state", {req_ready, rsp_valid, rsp_id, rsp_err, rsp_sat, busy, rsp_data}, 64'h0);
        do_reset();
        chk("idle_after_reset", {req_ready, rsp_valid, busy}, 4'h0);

        issue(0, 4'd0, 32'h10, 0);   chk("tp_load", last_data, 32'h10);
        issue(0, 4'd1, 32'h2, 0);    chk("tp_add", last_data, 32'h12);
        issue(0, 4'd2, 32'h2, 0);    chk("tp_sub", last_data, 32'h10);
        issue(0, 4'd3, 32'h2, 0);    chk("tp_mul", last_data, 32'h20);
        issue(0, 4'd6, 32'hFFFF, 0); chk("tp_and", last_data, 32'h20);
        issue(0, 4'd7, 32'hFFFF, 0); chk("tp_or", last_data, 32'hFFFF);
        issue(0, 4'd8, 32'hAAAA, 0); chk("tp_xor", last_data, 32'h5555);

        issue(1, 4'd0, 32'h8000_0040, 0);
        issue(1, 4'd10, 32'h6, 0);   chk("tp_shr", last_data, 32'h0200_0001);
        issue(1, 4'd0, 32'h8000_0040, 0);
        issue(1, 4'd12, 32'h6, 0);   chk("tp_ashr", last_data, 32'hFE00_0001);
        issue(1, 4'd0, 32'h3, 0);
        issue(1, 4'd9, 32'd14, 0);   chk("tp_shl", last_data, 32'h0000_C000);
        issue(1, 4'd11, 32'd2, 0);   chk("tp_ashl", last_data, 32'h0003_0000);
        issue(1, 4'd0, 32'h8000_0040, 0);
        issue(1, 4'd10, 32'h26, 0);  chk("tp_shamt", last_data, 32'h0200_0001);

        issue(0, 4'd0, 32'd100, 0);
        issue(0, 4'd4, 32'd7, 0);    chk("tp_div", last_data, 32'd14);
        issue(0, 4'd0, 32'd100, 0);
        issue(0, 4'd5, 32'd17, 0);   chk("tp_mod", last_data, 32'd15);
        issue(0, 4'd5, 32'd0, 0);    chk("tp_mod0", last_data, 32'd15);
        issue(0, 4'd4, 32'd0, 0);    chk("tp_div0", last_data, 32'hFFFF_FFFF);
        issue(1, 4'd0, 32'h1234, 0);
        issue(1, 4'd14, 32'h55, 3);  chk("tp_illegal", last_data, 32'h1234);

        issue(0, 4'd0, 32'h7FFF_FFFF, 0);
        issue(0, 4'd1, 32'h1, 0);
`ifdef ACC_SAT_EN
        chk("tp_sat", {rsp_sat, last_data}, {1'b1, 32'h7FFF_FFFF});
`else
        chk("tp_wrap", {rsp_sat, last_data}, {1'b0, 32'h8000_0000});
`endif

        // Both requesters contend continuously; grants must alternate starting from requester 0.
        do_reset();
        req_op = 8'h00;
        req_data = {32'hB1, 32'hA0};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int t;
            int win;
            #1;
            t = 0;
            while (req_ready == 2'b00 && t < 50) begin step(); t++; end
            win = m_rr;
            m_rr = 1 - win;
            chk("arb_grant", {62'd0, req_ready}, (win == 1) ? 64'd2 : 64'd1);
            chk("arb_order", win, k % 2);
            step();
            chk("arb_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, win[0], (win == 1) ? 32'hB1 : 32'hA0});
            if (k == 1) begin
                for (int h = 0; h < 5; h++) begin
                    step();
                    chk("arb_hold", {rsp_valid, rsp_id, req_ready, rsp_data}, {1'b1, 1'b1, 2'b00, 32'hB1});
                end
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
        req_valid = 2'b00;
        m_acc = 32'hB1;
        step();

        // A request withdrawn before the clock edge is never accepted.
        req_op[3:0] = 4'd0;
        req_valid[0] = 1'b1;
        #2;
        req_valid[0] = 1'b0;
        step();
        chk("withdraw", {busy, rsp_valid}, 2'b00);

        // Reset during divide aborts it without a response.
        issue(0, 4'd0, 32'd500, 0);
        req_op[3:0] = 4'd4;
        req_data[31:0] = 32'd3;
        req_valid[0] = 1'b1;
        #1;
        chk("rst_div_grant", {62'd0, req_ready}, 64'd1);
        step();
        req_valid[0] = 1'b0;
        for (int k = 0; k < 9; k++) step();
        chk("rst_div_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        chk("rst_div_abort", {busy, rsp_valid, req_ready}, 4'h0);
        rst = 1'b0;
        m_acc = 32'h0;
        m_rr = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_no_rsp", rsp_valid, 1'b0);
        end
        issue(0, 4'd1, 32'h0, 0);    chk("rst_acc", last_data, 32'h0);

        for (int n = 0; n < 40; n++) begin
            int          id;
            logic [3:0]  op;
            logic [31:0] d;
            id = $urandom_range(0, 1);
            op = 4'($urandom_range(0, 15));
            d  = $urandom;
            if ((op == 4'd4 || op == 4'd5) && $urandom_range(0, 3) == 0) d = $urandom_range(0, 20);
            issue(id, op, d, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
